// File: rtl/bias_requant_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bias_requant_unit
//  Purpose  : Accumulates one vector of signed MAC products, adds a bias, and
//             rounds, shifts and saturates the sum to a signed 16-bit result.
//  Revision : 1.0  initial release
// ============================================================================
module bias_requant_unit #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    clear,
   input  logic [LEN_W-1:0]        vec_len,
   input  logic signed [15:0]      bias,
   input  logic [3:0]              shift,
   input  logic                    prod_valid,
   input  logic signed [IN_W-1:0]  prod_data,
   output logic                    prod_ready,
   output logic signed [15:0]      out_data,
   output logic                    out_valid,
   output logic                    out_sat,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   localparam logic signed [ACC_W+1:0] SAT_MAX = (ACC_W+2)'(32767);
   localparam logic signed [ACC_W+1:0] SAT_MIN = (ACC_W+2)'(-32768);

   state_t                   state_q, state_d;
   logic [ACC_W-1:0]         acc_q, acc_d;
   logic [LEN_W-1:0]         cnt_q, cnt_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [15:0]              bias_q, bias_d;
   logic [3:0]               shift_q, shift_d;
   logic [15:0]              out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_sat_q, out_sat_d;

   logic [ACC_W:0]           round_c;
   logic [ACC_W:0]           rnd_sum;
   logic signed [ACC_W:0]    rounded;
   logic signed [ACC_W+1:0]  sum_s;
   logic [15:0]              res_data;
   logic                     res_sat;

   // One extra bit on the rounding add keeps a near-max accumulator from wrapping.
   always_comb begin
      round_c  = (shift_q != 4'd0) ? ((ACC_W+1)'(1) << (shift_q - 4'd1)) : '0;
      rnd_sum  = {acc_q[ACC_W-1], acc_q} + round_c;
      rounded  = $signed(rnd_sum) >>> shift_q;
      sum_s    = {rounded[ACC_W], rounded} + {{(ACC_W+2-16){bias_q[15]}}, bias_q};
      res_sat  = 1'b0;
      res_data = sum_s[15:0];
      if (sum_s > SAT_MAX) begin
         res_data = 16'h7FFF;
         res_sat  = 1'b1;
      end else if (sum_s < SAT_MIN) begin
         res_data = 16'h8000;
         res_sat  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      bias_d      = bias_q;
      shift_d     = shift_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_valid_d = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_d   = vec_len;
                  bias_d  = bias;
                  shift_d = shift;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = (vec_len != '0) ? S_ACCUM : S_FINAL;
               end
            end
            S_ACCUM: begin
               if (prod_valid) begin
                  acc_d = acc_q + {{(ACC_W-IN_W){prod_data[IN_W-1]}}, prod_data};
                  cnt_d = cnt_q + LEN_W'(1);
                  if (cnt_q == len_q - LEN_W'(1)) begin
                     state_d = S_FINAL;
                  end
               end
            end
            S_FINAL: begin
               out_data_d  = res_data;
               out_sat_d   = res_sat;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         bias_q      <= '0;
         shift_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         bias_q      <= bias_d;
         shift_q     <= shift_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign prod_ready = (state_q == S_ACCUM);
   assign busy       = (state_q != S_IDLE);
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_sat    = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_bias_requant_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bias_requant_unit
//  Purpose  : Directed plus randomized bench for bias_requant_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bias_requant_unit;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               clear = 1'b0;
   logic [7:0]         vec_len = '0;
   logic signed [15:0] bias = '0;
   logic [3:0]         shift = '0;
   logic               prod_valid = 1'b0;
   logic signed [15:0] prod_data = '0;
   logic               prod_ready;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_sat;
   logic               busy;

   int n_cmp = 0;
   int n_err = 0;
   int prods[$];
   int stl[$];
   logic signed [15:0] exp_d;
   logic               exp_s;

   bias_requant_unit #(.IN_W(16), .ACC_W(32), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .vec_len(vec_len), .bias(bias), .shift(shift),
      .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
      .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: exact integer arithmetic, floor division for the shift.
   function automatic void model(input int b, input int sh,
                                 output logic signed [15:0] d, output logic sat);
      longint acc;
      longint r;
      longint s;
      acc = 0;
      foreach (prods[i]) acc += prods[i];
      acc = longint'(int'(acc));
      r = acc + ((sh != 0) ? (longint'(1) << (sh - 1)) : 0);
      r = r >>> sh;
      s = r + b;
      sat = 1'b0;
      if (s > 32767) begin s = 32767; sat = 1'b1; end
      else if (s < -32768) begin s = -32768; sat = 1'b1; end
      d = 16'(s);
   endfunction

   task automatic start_vec(input int len, input int b, input int sh);
      start = 1'b1; vec_len = 8'(len); bias = 16'(b); shift = 4'(sh);
      model(b, sh, exp_d, exp_s);
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("ready_after_start", prod_ready, (len != 0) ? 1 : 0);
   endtask

   // Ends positioned in the out_valid cycle.
   task automatic feed(input int len, input bit poke);
      for (int i = 0; i < len; i++) begin
         for (int k = 0; k < stl[i]; k++) begin
            prod_valid = 1'b0; prod_data = 16'($urandom);
            tick();
         end
         prod_valid = 1'b1; prod_data = 16'(prods[i]);
         chk("beat_ready", prod_ready, 1);
         if (poke && i == 1) begin
            start = 1'b1; vec_len = 8'(len + 3); bias = 16'($urandom);
         end
         tick();
         start = 1'b0;
      end
      prod_valid = 1'b0;
      chk("final_ready", prod_ready, 0);
      chk("final_no_valid", out_valid, 0);
      tick();
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_d);
      chk("out_sat", out_sat, exp_s);
   endtask

   task automatic end_vec();
      tick();
      chk("valid_pulse_end", out_valid, 0);
      chk("data_hold", out_data, exp_d);
      chk("idle_busy", busy, 0);
   endtask

   task automatic set_vec(input int n);
      stl = {};
      for (int i = 0; i < n; i++) stl.push_back(0);
   endtask

   initial begin
      logic signed [15:0] t16;
      int len, b, sh;
      repeat (2) tick();
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_ready", prod_ready, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      prods = {1, 2, 3, 4}; set_vec(4);
      start_vec(4, 10, 0); feed(4, 0); end_vec();

      prods = {-3, -2}; set_vec(2);
      start_vec(2, 0, 2); feed(2, 0); end_vec();
      prods = {3, 3}; set_vec(2);
      start_vec(2, 0, 2); feed(2, 0); end_vec();

      prods = {32767, 32767, 32767}; set_vec(3);
      start_vec(3, 100, 0); feed(3, 0); end_vec();
      prods = {-32767, -32767, -32767}; set_vec(3);
      start_vec(3, -100, 0); feed(3, 0); end_vec();

      prods = {4, 5, 6}; stl = {0, 2, 0};
      start_vec(3, 0, 0); feed(3, 0); end_vec();

      prods = {}; set_vec(0);
      start_vec(0, -7, 0); feed(0, 0); end_vec();

      // Abort after two beats, with a colliding start that must be dropped.
      prods = {1, 2, 3, 4};
      start = 1'b1; vec_len = 8'd4; bias = 16'sd0; shift = 4'd0;
      tick(); start = 1'b0;
      prod_valid = 1'b1; prod_data = 16'sd1; tick();
      prod_data = 16'sd2; tick();
      clear = 1'b1; start = 1'b1; prod_data = 16'sd3; tick();
      clear = 1'b0; start = 1'b0; prod_valid = 1'b0;
      chk("clear_busy", busy, 0);
      chk("clear_no_valid", out_valid, 0);
      repeat (3) begin
         tick();
         chk("clear_quiet", out_valid | busy, 0);
      end
      prods = {5, 5}; set_vec(2);
      start_vec(2, 0, 0); feed(2, 0); end_vec();

      prods = {7, 8, 9, 10, 11}; set_vec(5);
      start_vec(5, 3, 1); feed(5, 1); end_vec();

      prods = {100, 200}; set_vec(2);
      start_vec(2, 1, 0); feed(2, 0);
      prods = {-50, 20, 7}; set_vec(3);
      start_vec(3, -4, 1); feed(3, 0); end_vec();

      for (int it = 0; it < 14; it++) begin
         len = $urandom_range(0, 12);
         prods = {}; stl = {};
         for (int i = 0; i < len; i++) begin
            t16 = 16'($urandom);
            prods.push_back(int'(t16));
            stl.push_back($urandom_range(0, 2));
         end
         t16 = 16'($urandom);
         b = int'(t16);
         sh = $urandom_range(0, 15);
         start_vec(len, b, sh);
         feed(len, len >= 2 && $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) end_vec();
      end
      end_vec();

      // Asynchronous reset in the middle of a vector.
      prods = {1, 1, 1, 1};
      start = 1'b1; vec_len = 8'd4; bias = 16'sd0; shift = 4'd0;
      tick(); start = 1'b0;
      prod_valid = 1'b1; prod_data = 16'sd1; tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_sat", out_sat, 0);
      chk("mid_rst_ready", prod_ready, 0);
      chk("mid_rst_busy", busy, 0);
      prod_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      prods = {2, 3}; set_vec(2);
      start_vec(2, 0, 0); feed(2, 0); end_vec();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
